// File: rtl/uart_bus_bridge.sv
// UART-driven bus initiator: parses read/write packets from the RX byte stream,
// issues one bus request per packet and returns status (plus read data) over TX.
module uart_bus_bridge #(
    parameter int BUS_TIMEOUT  = 1024,
    parameter int BYTE_TIMEOUT = 100000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        write_o,
    output logic [31:0] write_address_o,
    output logic [31:0] write_data_o,
    input  logic        write_done_i,
    input  logic        write_error_i,
    output logic        read_o,
    output logic [31:0] read_address_o,
    input  logic [31:0] read_data_i,
    input  logic        read_done_i,
    input  logic        read_error_i,
    output logic        busy_o,
    output logic        overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_READ,
        S_RESP
    } state_e;

    localparam logic [7:0]  OP_WRITE   = 8'hA5;
    localparam logic [7:0]  OP_READ    = 8'h5A;
    localparam logic [1:0]  ST_OK      = 2'd0;
    localparam logic [1:0]  ST_BUS_ERR = 2'd1;
    localparam logic [1:0]  ST_TIMEOUT = 2'd2;
    localparam logic [1:0]  ST_BAD_CMD = 2'd3;
    localparam logic [31:0] BUS_LAST   = 32'(BUS_TIMEOUT - 1);
    localparam logic [31:0] BYTE_LAST  = 32'(BYTE_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  status_q, status_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  resp_idx_q, resp_idx_d;
    logic [2:0]  resp_last_q, resp_last_d;
    logic [1:0]  data_sel;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            is_write_q  <= 1'b0;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            timer_q     <= '0;
            status_q    <= '0;
            rdata_q     <= '0;
            resp_idx_q  <= '0;
            resp_last_q <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register
            // samples the pre-edge values; the comb block below uses blocking ones.
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            timer_q     <= timer_d;
            status_q    <= status_d;
            rdata_q     <= rdata_d;
            resp_idx_q  <= resp_idx_d;
            resp_last_q <= resp_last_d;
        end
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a latch.
        state_d     = state_q;
        is_write_d  = is_write_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        timer_d     = timer_q;
        status_d    = status_q;
        rdata_d     = rdata_q;
        resp_idx_d  = resp_idx_q;
        resp_last_d = resp_last_q;

        unique case (state_q)
            S_IDLE: begin
                timer_d    = '0;
                byte_cnt_d = '0;
                resp_idx_d = '0;
                if (rx_valid_i) begin
                    if (rx_data_i == OP_WRITE) begin
                        is_write_d = 1'b1;
                        state_d    = S_ADDR;
                    end else if (rx_data_i == OP_READ) begin
                        is_write_d = 1'b0;
                        state_d    = S_ADDR;
                    end else begin
                        status_d    = ST_BAD_CMD;
                        rdata_d     = '0;
                        resp_last_d = 3'd0;
                        state_d     = S_RESP;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (rx_valid_i) begin
                    timer_d    = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (state_q == S_ADDR) addr_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
                    else                   data_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
                    if (byte_cnt_q == 2'd3) begin
                        if (state_q == S_DATA) state_d = S_WRITE;
                        else                   state_d = is_write_q ? S_DATA : S_READ;
                    end
                end else if (timer_q == BYTE_LAST) begin
                    // Stale partial packet: drop it silently.
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_WRITE: begin
                resp_last_d = 3'd0;
                if (write_done_i) begin
                    status_d = write_error_i ? ST_BUS_ERR : ST_OK;
                    state_d  = S_RESP;
                end else if (timer_q == BUS_LAST) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_RESP;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_READ: begin
                resp_last_d = 3'd4;
                if (read_done_i) begin
                    status_d = read_error_i ? ST_BUS_ERR : ST_OK;
                    rdata_d  = read_error_i ? '0 : read_data_i;
                    state_d  = S_RESP;
                end else if (timer_q == BUS_LAST) begin
                    status_d = ST_TIMEOUT;
                    rdata_d  = '0;
                    state_d  = S_RESP;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_RESP: begin
                if (tx_ready_i) begin
                    if (resp_idx_q == resp_last_q) state_d = S_IDLE;
                    else                           resp_idx_d = resp_idx_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte 0 is the status; bytes 1..4 are read data, little-endian.
    assign data_sel = 2'(resp_idx_q - 3'd1);

    always_comb begin
        busy_o          = (state_q != S_IDLE);
        write_o         = (state_q == S_WRITE);
        read_o          = (state_q == S_READ);
        tx_valid_o      = (state_q == S_RESP);
        write_address_o = addr_q;
        write_data_o    = data_q;
        read_address_o  = addr_q;
        overrun_o       = rx_valid_i &&
                          (state_q == S_WRITE || state_q == S_READ || state_q == S_RESP);
        tx_data_o       = '0;
        if (state_q == S_RESP) begin
            if (resp_idx_q == 3'd0) tx_data_o = {6'b0, status_q};
            else                    tx_data_o = rdata_q[{data_sel, 3'b000} +: 8];
        end
    end

endmodule
